// File: rtl/gpio_trace_pkg.sv
// Shared types and constants for the GPIO trace capture unit.
package gpio_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } trace_state_e;

  localparam int unsigned DROP_W = 8;

endpackage

// File: rtl/gpio_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO succeeds
// only when a pop happens on the same edge.
module gpio_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Stale storage is masked so the head reads as zero while empty.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gpio_trace_capture.sv
// Timestamped change capture of GPIO lines into a FIFO, started by a rising
// arm trigger, with wrap markers and sticky overflow/drop reporting.
module gpio_trace_capture
  import gpio_trace_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int TS_W  = 24,
  parameter int DEPTH = 16,
  parameter int PS_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        arm_i,
  input  logic [PS_W-1:0]             prescale_i,
  input  logic [N_CH-1:0]             gpio_i,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [N_CH+TS_W:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        capturing,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic [DROP_W-1:0]           drop_cnt
);

  localparam int ENTRY_W = 1 + N_CH + TS_W;

  typedef struct packed {
    logic            wrap;
    logic [N_CH-1:0] gpio;
    logic [TS_W-1:0] ts;
  } entry_t;

  trace_state_e    state, state_d;
  logic            arm_q;
  logic [N_CH-1:0] g_q;
  logic [N_CH-1:0] prev;
  logic [TS_W-1:0] ts;
  logic [PS_W-1:0] ps;
  logic            started;

  logic   in_cap, tick, wrap_now, change, push, drop, full, empty;
  entry_t ent;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (enable) state_d = ARMED;
      ARMED:   if (!arm_q && arm_i) state_d = CAPTURE;
      CAPTURE: state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // The first capture cycle records the initial line state; later cycles log
  // changes and wrap markers, merged into one entry when they coincide.
  always_comb begin
    in_cap   = (state == CAPTURE);
    tick     = in_cap && (ps == prescale_i);
    wrap_now = in_cap && started && tick && (&ts);
    change   = in_cap && started && (g_q != prev);
    push     = (in_cap && !started) || wrap_now || change;
    ent.wrap = wrap_now;
    ent.gpio = g_q;
    ent.ts   = wrap_now ? '0 : ts;
  end

  assign drop      = push && full && !(rd_en && !empty);
  assign rd_valid  = !empty;
  assign capturing = in_cap;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      arm_q    <= 1'b0;
      g_q      <= '0;
      prev     <= '0;
      ts       <= '0;
      ps       <= '0;
      started  <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_d;
      arm_q <= arm_i;
      g_q   <= gpio_i;
      if (in_cap) begin
        started <= 1'b1;
        prev    <= g_q;
        if (tick) begin
          ps <= '0;
          ts <= ts + 1'b1;
        end else begin
          ps <= ps + 1'b1;
        end
      end else begin
        started <= 1'b0;
        ps      <= '0;
        ts      <= '0;
      end
      if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  gpio_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_en),
    .wdata (ent),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_gpio_trace_capture.sv
// Scenario bench for gpio_trace_capture using a small-timestamp, shallow-FIFO build.
module tb_gpio_trace_capture;

  localparam int N_CH    = 4;
  localparam int TS_W    = 4;
  localparam int DEPTH   = 4;
  localparam int PS_W    = 16;
  localparam int ENTRY_W = 1 + N_CH + TS_W;
  localparam int LVL_W   = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               rst, enable, arm_i, rd_en, ovf_clr;
  logic [PS_W-1:0]    prescale_i;
  logic [N_CH-1:0]    gpio_i;
  logic               rd_valid, capturing, overflow;
  logic [ENTRY_W-1:0] rd_data;
  logic [LVL_W-1:0]   level;
  logic [7:0]         drop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [ENTRY_W-1:0] exp_q [$];

  gpio_trace_capture #(
    .N_CH(N_CH), .TS_W(TS_W), .DEPTH(DEPTH), .PS_W(PS_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .arm_i(arm_i),
    .prescale_i(prescale_i), .gpio_i(gpio_i), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .capturing(capturing), .overflow(overflow), .ovf_clr(ovf_clr),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [ENTRY_W-1:0] mk(input logic w, input logic [N_CH-1:0] g,
                                            input logic [TS_W-1:0] t);
    return {w, g, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  // Scoreboard consumer: compare the FIFO head with the oldest expectation, then pop it.
  task automatic sb_read(input string name);
    logic [ENTRY_W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, rd_valid=%b rd_data=%h", name, rd_valid, rd_data);
    end else begin
      e = exp_q.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        errors++;
        $display("FAIL %s: rd_valid=%b rd_data=%h, expected rd_valid=1 rd_data=%h",
                 name, rd_valid, rd_data, e);
      end
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; arm_i = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    prescale_i = '0; gpio_i = '0;
    step(); step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL reset_capturing: got %b want 0", capturing); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_initial_record();
    prescale_i = 16'd1000; gpio_i = 4'b0101; enable = 1'b1;
    step(); step();
    arm_i = 1'b1;
    exp_q.push_back(mk(1'b0, 4'b0101, 4'd0));
    step();
    checks++; if (capturing !== 1'b1) begin errors++; $display("FAIL init_capturing: got %b want 1", capturing); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL init_valid_early: got %b want 0", rd_valid); end
    step();
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL init_level: got %0d want 1", level); end
    sb_read("init_record");
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL init_drained: got %0d want 0", level); end
    enable = 1'b0; arm_i = 1'b0;
    step();
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL init_disable: got %b want 0", capturing); end
  endtask

  task automatic test_change_timing();
    prescale_i = 16'd3; enable = 1'b1;
    step();
    arm_i = 1'b1;
    step(); cyc = 0;
    exp_q.push_back(mk(1'b0, 4'b0101, 4'd0));
    goto(38);
    gpio_i = 4'b0111;
    exp_q.push_back(mk(1'b0, 4'b0111, 4'd9));
    goto(41);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL change_one_entry: level=%0d want 2", level); end
    goto(50);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL change_stable: level=%0d want 2", level); end
    enable = 1'b0; arm_i = 1'b0;
    step();
    sb_read("timing_init");
    sb_read("timing_change");
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL timing_drained: level=%0d want 0", level); end
  endtask

  task automatic test_wrap();
    prescale_i = '0; gpio_i = 4'b0011; enable = 1'b1;
    step(); step();
    arm_i = 1'b1;
    step(); cyc = 0;
    exp_q.push_back(mk(1'b0, 4'b0011, 4'd0));
    goto(1);
    sb_read("wrap_init");
    goto(16);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL wrap_marker_level: level=%0d want 1", level); end
    exp_q.push_back(mk(1'b1, 4'b0011, 4'd0));
    sb_read("wrap_marker");
    goto(30);
    gpio_i = 4'b1100;
    exp_q.push_back(mk(1'b1, 4'b1100, 4'd0));
    goto(32);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL wrap_merged_single: level=%0d want 1", level); end
    sb_read("wrap_merged");
    goto(48);
    exp_q.push_back(mk(1'b1, 4'b1100, 4'd0));
    sb_read("wrap_marker_prev");
    enable = 1'b0; arm_i = 1'b0;
    step();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL wrap_drained: level=%0d want 0", level); end
  endtask

  task automatic test_overflow_and_full();
    prescale_i = 16'd1000; gpio_i = 4'b0000; enable = 1'b1;
    step(); step();
    arm_i = 1'b1;
    step(); cyc = 0;
    exp_q.push_back(mk(1'b0, 4'b0000, 4'd0));
    for (int i = 1; i <= 5; i++) begin
      gpio_i = N_CH'(i);
      if (i <= 3) exp_q.push_back(mk(1'b0, N_CH'(i), 4'd0));
      step(); step();
    end
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: level=%0d want 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL ovf_clear: overflow=%b drop_cnt=%0d want 0/0", overflow, drop_cnt);
    end
    for (int i = 0; i < 260; i++) begin
      gpio_i = (i % 2 == 1) ? 4'b1010 : 4'b0101;
      step();
    end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt); end
    ovf_clr = 1'b1; step();
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_priority: overflow=%b drop_cnt=%0d want 0/0", overflow, drop_cnt);
    end
    ovf_clr = 1'b0; step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL no_spurious_drop: overflow=%b want 0", overflow); end
    gpio_i = 4'b0110;
    exp_q.push_back(mk(1'b0, 4'b0110, 4'd0));
    step();
    sb_read("full_pop_head");
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level_kept: level=%0d want 4", level); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL full_no_drop: overflow=%b drop_cnt=%0d want 0/0", overflow, drop_cnt);
    end
    for (int i = 0; i < 4; i++) sb_read($sformatf("ovf_read_%0d", i));
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovf_drained: level=%0d want 0", level); end
    enable = 1'b0; arm_i = 1'b0;
    step();
  endtask

  task automatic test_arm_disable();
    gpio_i = 4'b1001; arm_i = 1'b1; enable = 1'b0;
    step();
    enable = 1'b1;
    step(); step(); step(); step();
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL arm_level_no_trigger: capturing=%b want 0", capturing); end
    arm_i = 1'b0; step();
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL arm_low: capturing=%b want 0", capturing); end
    arm_i = 1'b1; step();
    checks++; if (capturing !== 1'b1) begin errors++; $display("FAIL arm_rising: capturing=%b want 1", capturing); end
    exp_q.push_back(mk(1'b0, 4'b1001, 4'd0));
    step();
    enable = 1'b0; step();
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL disable_idle: capturing=%b want 0", capturing); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL disable_retained: level=%0d want 1", level); end
    sb_read("retained_entry");
    enable = 1'b1; arm_i = 1'b0; step();
    arm_i = 1'b1; step(); step();
    gpio_i = 4'b0110; step(); step();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL pre_reset_level: level=%0d want 2", level); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (level !== '0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_fifo: level=%0d rd_valid=%b want 0/0", level, rd_valid);
    end
    checks++; if (capturing !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_reset_state: capturing=%b overflow=%b drop_cnt=%0d want 0/0/0",
                         capturing, overflow, drop_cnt);
    end
    enable = 1'b0; arm_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_initial_record();
    test_change_timing();
    test_wrap();
    test_overflow_and_full();
    test_arm_disable();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: %0d entries never read", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
